// File: rtl/imem_port_arbiter_if.sv
// Bundle of the fetch, loader and RAM-side signals around the instruction-memory port arbiter.
// The slave modport is the arbiter; the master modport is the surrounding CPU/loader/RAM environment.
interface imem_port_arbiter_if;
    logic        fetch_req_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_gnt_o;
    logic [31:0] fetch_instr_o;
    logic        fetch_vld_o;

    logic        load_req_i;
    logic [31:0] load_addr_i;
    logic [31:0] load_data_i;
    logic        load_gnt_o;

    logic [31:0] addr_imem_ram_o;
    logic [31:0] wr_instr_imem_ram_o;
    logic        wr_en_imem_ram_o;
    logic [31:0] read_instr_imem_ram_i;

    modport slave (
        input  fetch_req_i, fetch_addr_i, load_req_i, load_addr_i, load_data_i,
        input  read_instr_imem_ram_i,
        output fetch_gnt_o, fetch_instr_o, fetch_vld_o, load_gnt_o,
        output addr_imem_ram_o, wr_instr_imem_ram_o, wr_en_imem_ram_o
    );

    modport master (
        output fetch_req_i, fetch_addr_i, load_req_i, load_addr_i, load_data_i,
        output read_instr_imem_ram_i,
        input  fetch_gnt_o, fetch_instr_o, fetch_vld_o, load_gnt_o,
        input  addr_imem_ram_o, wr_instr_imem_ram_o, wr_en_imem_ram_o
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Single-port instruction RAM arbiter between CPU fetch and program loader; grants are
// combinational, fetch data returns one cycle later, loader bursts are capped while a fetch waits.
module imem_port_arbiter #(
    parameter int MAX_LOAD_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    imem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_LOAD_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_LOAD_BURST);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic [31:0]      instr_q, instr_d;
    logic             load_win;
    logic             fetch_gnt;
    logic             load_gnt;

    // Loader wins unless a fetch is waiting and the burst allowance is used up.
    always_comb begin
        load_win  = bus.load_req_i && (!bus.fetch_req_i || (burst_q < BURST_MAX));
        load_gnt  = !reset && load_win;
        fetch_gnt = !reset && bus.fetch_req_i && !load_win;
    end

    always_comb begin
        bus.addr_imem_ram_o     = 32'h0;
        bus.wr_instr_imem_ram_o = 32'h0;
        bus.wr_en_imem_ram_o    = 1'b0;
        if (load_gnt) begin
            bus.addr_imem_ram_o     = bus.load_addr_i & ~32'h3;
            bus.wr_instr_imem_ram_o = bus.load_data_i;
            bus.wr_en_imem_ram_o    = 1'b1;
        end else if (fetch_gnt) begin
            bus.addr_imem_ram_o     = bus.fetch_addr_i & ~32'h3;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        if (fetch_gnt) begin
            state_d = ST_FETCH;
        end else if (load_gnt) begin
            state_d = ST_LOAD;
        end

        burst_d = burst_q;
        if (!bus.load_req_i || fetch_gnt) begin
            burst_d = '0;
        end else if (load_gnt && bus.fetch_req_i && (burst_q < BURST_MAX)) begin
            burst_d = burst_q + 1'b1;
        end

        instr_d = fetch_gnt ? bus.read_instr_imem_ram_i : instr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            burst_q <= '0;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            instr_q <= instr_d;
        end
    end

    assign bus.fetch_gnt_o   = fetch_gnt;
    assign bus.load_gnt_o    = load_gnt;
    assign bus.fetch_instr_o = instr_q;
    // A fetch granted last cycle is exactly what the FETCH state records.
    assign bus.fetch_vld_o   = (state_q == ST_FETCH);
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: RAM model, reference arbitration model and fetch-data scoreboard.
module tb_imem_port_arbiter;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic reset;
    logic ram_init;
    always #5 clk = ~clk;

    imem_port_arbiter_if bus ();

    imem_port_arbiter #(.MAX_LOAD_BURST(MAXB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] ram [256];
    logic [31:0] ref_mem [256];

    function automatic logic [7:0] widx(input logic [31:0] a);
        return 8'((a >> 2) & 32'hFF);
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (bus.wr_en_imem_ram_o) begin
            ram[widx(bus.addr_imem_ram_o)] <= bus.wr_instr_imem_ram_o;
        end
    end
    assign bus.read_instr_imem_ram_i = ram[widx(bus.addr_imem_ram_o)];

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb [$];
    int  mdl_cnt;
    bit  mdl_vld;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One arbitration cycle: drive, compare at the falling edge, advance the reference model.
    task automatic step(input bit freq, input logic [31:0] faddr, input bit lreq,
                        input logic [31:0] laddr, input logic [31:0] ldata, output bit saw_load);
        bit exp_lg, exp_fg;
        bus.fetch_req_i  = freq;
        bus.fetch_addr_i = faddr;
        bus.load_req_i   = lreq;
        bus.load_addr_i  = laddr;
        bus.load_data_i  = ldata;
        @(negedge clk);
        check("fetch_vld", 32'(bus.fetch_vld_o), 32'(mdl_vld));
        if (bus.fetch_vld_o) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) check("fetch_instr", bus.fetch_instr_o, sb.pop_front());
        end
        exp_lg = lreq && (!freq || mdl_cnt < MAXB);
        exp_fg = freq && !exp_lg;
        check("load_gnt", 32'(bus.load_gnt_o), 32'(exp_lg));
        check("fetch_gnt", 32'(bus.fetch_gnt_o), 32'(exp_fg));
        check("wr_en", 32'(bus.wr_en_imem_ram_o), 32'(exp_lg));
        if (exp_lg) begin
            check("load_addr", bus.addr_imem_ram_o, {laddr[31:2], 2'b00});
            check("load_wdata", bus.wr_instr_imem_ram_o, ldata);
            ref_mem[widx(laddr)] = ldata;
        end else if (exp_fg) begin
            check("fetch_addr", bus.addr_imem_ram_o, {faddr[31:2], 2'b00});
            sb.push_back(ref_mem[widx(faddr)]);
        end else begin
            check("idle_addr", bus.addr_imem_ram_o, 32'h0);
            check("idle_wdata", bus.wr_instr_imem_ram_o, 32'h0);
        end
        if (!lreq || exp_fg) mdl_cnt = 0;
        else if (exp_lg && freq && mdl_cnt < MAXB) mdl_cnt++;
        mdl_vld  = exp_fg;
        saw_load = bus.load_gnt_o;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bit d;
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, d);
    endtask

    initial begin
        bit          lg;
        logic [9:0]  pat10;
        logic [8:0]  pat9;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        mdl_cnt = 0;
        mdl_vld = 1'b0;
        ram_init = 1'b1;
        reset = 1'b1;
        bus.fetch_req_i  = 1'b1;
        bus.fetch_addr_i = 32'h20;
        bus.load_req_i   = 1'b1;
        bus.load_addr_i  = 32'h24;
        bus.load_data_i  = 32'h1111_2222;
        #3;
        check("rst_fetch_gnt", 32'(bus.fetch_gnt_o), 32'd0);
        check("rst_load_gnt", 32'(bus.load_gnt_o), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en_imem_ram_o), 32'd0);
        check("rst_addr", bus.addr_imem_ram_o, 32'h0);
        check("rst_vld", 32'(bus.fetch_vld_o), 32'd0);
        check("rst_instr", bus.fetch_instr_o, 32'h0);
        check("rst_state", 32'(dut.state_q), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        ram_init = 1'b0;
        reset = 1'b0;

        // Word-aligned fetch, then loader write followed by a fetch of the same word.
        step(1'b1, 32'h0000_0106, 1'b0, 32'h0, 32'h0, lg);
        idle();
        step(1'b0, 32'h0, 1'b1, 32'h10, 32'hDEAD_BEEF, lg);
        step(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, lg);
        idle();

        // Contested port: four loader grants then one forced fetch.
        pat10 = '0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h200 + 32'(i * 4), 1'b1, 32'h300 + 32'(i * 4), $urandom, lg);
            pat10 = {pat10[8:0], lg};
        end
        check("burst_pattern", 32'(pat10), 32'h3DE);
        idle();

        // Loader pause after three grants restarts the burst allowance.
        pat9 = '0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 32'h100 + 32'(i * 4), (i != 3), 32'h380 + 32'(i * 4), $urandom, lg);
            pat9 = {pat9[7:0], lg};
        end
        check("burst_restart", 32'(pat9), 32'h1DE);
        idle();

        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), $urandom & 32'h3FF,
                 1'($urandom_range(0, 1)), $urandom & 32'h3FF, $urandom, lg);
        end
        idle();

        // Reset in the middle of a load grant: the write must be suppressed immediately.
        step(1'b1, 32'h44, 1'b0, 32'h0, 32'h0, lg);
        bus.fetch_req_i = 1'b0;
        bus.load_req_i  = 1'b1;
        bus.load_addr_i = 32'h40;
        bus.load_data_i = 32'h1234_5678;
        #2;
        check("pre_rst_wr_en", 32'(bus.wr_en_imem_ram_o), 32'd1);
        check("pre_rst_vld", 32'(bus.fetch_vld_o), 32'd1);
        if (sb.size() > 0) check("pre_rst_instr", bus.fetch_instr_o, sb.pop_front());
        reset = 1'b1;
        #1;
        check("mid_rst_wr_en", 32'(bus.wr_en_imem_ram_o), 32'd0);
        check("mid_rst_load_gnt", 32'(bus.load_gnt_o), 32'd0);
        check("mid_rst_vld", 32'(bus.fetch_vld_o), 32'd0);
        check("mid_rst_instr", bus.fetch_instr_o, 32'h0);
        check("mid_rst_state", 32'(dut.state_q), 32'd0);
        mdl_cnt = 0;
        mdl_vld = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        bus.load_req_i = 1'b0;
        reset = 1'b0;
        check("post_rst_state", 32'(dut.state_q), 32'd0);
        step(1'b1, 32'h40, 1'b0, 32'h0, 32'h0, lg);
        idle();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/imem_port_arbiter.md
IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_LOAD_BURST, default 4: maximum consecutive loader grants while a fetch is pending.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port fetch_req_i, input, 1: CPU fetch requests one instruction read this cycle.
REQ-005 SHALL have port fetch_addr_i, input, 32: byte address of the fetch.
REQ-006 SHALL have port fetch_gnt_o, output, 1: fetch owns the RAM port this cycle.
REQ-007 SHALL have port fetch_instr_o, output, 32: registered instruction for the last granted fetch.
REQ-008 SHALL have port fetch_vld_o, output, 1: fetch_instr_o is valid this cycle.
REQ-009 SHALL have port load_req_i, input, 1: program loader requests one word write this cycle.
REQ-010 SHALL have port load_addr_i, input, 32: byte address of the write.
REQ-011 SHALL have port load_data_i, input, 32: word to write.
REQ-012 SHALL have port load_gnt_o, output, 1: loader owns the RAM port this cycle; the write commits at the next rising edge.
REQ-013 SHALL have port addr_imem_ram_o, output, 32: RAM address.
REQ-014 SHALL have port wr_instr_imem_ram_o, output, 32: RAM write data.
REQ-015 SHALL have port wr_en_imem_ram_o, output, 1: RAM write enable.
REQ-016 SHALL have port read_instr_imem_ram_i, input, 32: combinational RAM read data.

Function
REQ-017 SHALL grant at most one requester per cycle; fetch_gnt_o and load_gnt_o are never both 1.
REQ-018 SHALL compute grants combinationally from the current-cycle requests plus registered state, so a transfer completes in a single cycle.
REQ-019 SHALL hold state IDLE, FETCH or LOAD, meaning the owner granted in the previous cycle; next state is FETCH, LOAD or IDLE according to the current grant.
REQ-020 SHALL hold a burst counter, width clog2(MAX_LOAD_BURST+1), and SHALL apply the rules below.
REQ-021 Counter SHALL increment on a load grant while fetch_req_i=1.
REQ-022 Counter SHALL clear on a fetch grant, and on any cycle with load_req_i=0.
REQ-023 Counter SHALL saturate at MAX_LOAD_BURST.
REQ-024 When only one request is high, that requester SHALL be granted.
REQ-025 When both requests are high, the loader SHALL be granted if counter < MAX_LOAD_BURST; otherwise fetch SHALL be granted for exactly that cycle.
REQ-026 With no grant: addr_imem_ram_o=0, wr_instr_imem_ram_o=0, wr_en_imem_ram_o=0.
REQ-027 On fetch grant: addr_imem_ram_o = fetch_addr_i with bits[1:0] forced to 0, and wr_en_imem_ram_o=0.
REQ-028 On load grant: addr_imem_ram_o = load_addr_i with bits[1:0] forced to 0; wr_instr_imem_ram_o=load_data_i; wr_en_imem_ram_o=1.
REQ-029 Fetch latency SHALL be 1 cycle: on a fetch grant, read_instr_imem_ram_i is captured into fetch_instr_o at the rising edge, with fetch_vld_o=1 for the following cycle only.
REQ-030 fetch_instr_o SHALL hold its value when no fetch is granted.
REQ-031 A fetch granted in the cycle after a load grant to the same word SHALL return the newly written data; no bypass is needed because the RAM write commits at that edge.
REQ-032 While reset=1, both grants and wr_en_imem_ram_o SHALL be 0 combinationally, so no write occurs during reset.

Reset
REQ-033 On reset: state=IDLE, counter=0, fetch_vld_o=0, fetch_instr_o=0, all grants 0, all RAM outputs 0.
REQ-034 On reset release, arbitration SHALL resume from IDLE on the first rising edge, with no pending transfer carried over.

Verification
REQ-035 Fetch only, fetch_addr_i=0x0000_0106 -> fetch_gnt_o=1 and addr_imem_ram_o=0x0000_0104; next cycle fetch_vld_o=1 with the RAM word.
REQ-036 Load 0xDEAD_BEEF to 0x10, then fetch 0x10 next cycle -> wr_en_imem_ram_o=1 in cycle 1; fetch_instr_o=0xDEAD_BEEF in cycle 3.
REQ-037 Both requests held high for 10 cycles, MAX_LOAD_BURST=4 -> grant pattern L,L,L,L,F,L,L,L,L,F.
REQ-038 Both requests high; load_req_i drops for 1 cycle after 3 loader grants -> counter clears; next 4 contested cycles are loader grants.
REQ-039 reset asserted mid-cycle during a load grant -> wr_en_imem_ram_o falls immediately, no RAM write occurs, fetch_vld_o=0 and state=IDLE.
